// File: rtl/lcd_capture.sv
// lcd_capture: snoops an HD44102-style multi-chip LCD bus and turns data writes into framebuffer writes.
module lcd_capture #(
  parameter int LCD_MODULES     = 10,
  parameter int MODULES_PER_ROW = 5,
  parameter int X_PER_MODULE    = 50,
  parameter int MAX_X           = 240
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_pin,
  input  logic [LCD_MODULES-1:0] cs_pin,
  input  logic                   di_pin,
  input  logic                   rw_pin,
  input  logic                   enable_pin,
  input  logic                   reset_pin,
  output logic                   fb_we,
  output logic [7:0]             fb_x,
  output logic [2:0]             fb_y,
  output logic [7:0]             fb_data,
  output logic                   frame_strobe,
  output logic [LCD_MODULES-1:0] display_on
);
  localparam int SW = LCD_MODULES + 12;
  localparam int MW = $clog2(LCD_MODULES);

  logic [SW-1:0] s1, s2;
  logic s3_en;
  logic [7:0] d2;
  logic [LCD_MODULES-1:0] cs2;
  logic di2, rw2, en2, rp2;

  logic cap_v, cap_di;
  logic [7:0] cap_d;
  logic [LCD_MODULES-1:0] cap_cs;

  logic [LCD_MODULES-1:0][5:0] col;
  logic [LCD_MODULES-1:0][1:0] page;
  logic [LCD_MODULES-1:0][1:0] start_page_unused;
  logic [LCD_MODULES-1:0] up;

  logic [MW-1:0] wm;
  logic [5:0] wcol;
  logic [1:0] wpage;
  int wx;
  logic wok, lower;

  assign {d2, cs2, di2, rw2, en2, rp2} = s2;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      s3_en <= 1'b0;
    end else begin
      s1    <= {data_pin, cs_pin, di_pin, rw_pin, enable_pin, reset_pin};
      s2    <= s1;
      s3_en <= en2;
    end

  // Bus is sampled from the same synchroniser stage that shows enable low.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cap_v  <= 1'b0;
      cap_di <= 1'b0;
      cap_d  <= '0;
      cap_cs <= '0;
    end else begin
      cap_v  <= s3_en && !en2 && rp2 && !rw2 && |cs2;
      cap_di <= di2;
      cap_d  <= d2;
      cap_cs <= cs2;
    end

  always_comb begin
    wm = '0;
    for (int i = LCD_MODULES - 1; i >= 0; i--)
      if (cap_cs[i]) wm = MW'(i);
    wcol  = col[wm];
    wpage = page[wm];
    wx    = (int'(wm) % MODULES_PER_ROW) * X_PER_MODULE + int'(wcol);
    wok   = int'(wcol) < X_PER_MODULE && wx < MAX_X;
    lower = int'(wm) >= MODULES_PER_ROW;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fb_we             <= 1'b0;
      fb_x              <= '0;
      fb_y              <= '0;
      fb_data           <= '0;
      frame_strobe      <= 1'b0;
      col               <= '0;
      page              <= '0;
      start_page_unused <= '0;
      up                <= '1;
      display_on        <= '0;
    end else if (!rp2) begin
      fb_we             <= 1'b0;
      frame_strobe      <= 1'b0;
      col               <= '0;
      page              <= '0;
      start_page_unused <= '0;
      up                <= '1;
      display_on        <= '0;
    end else begin
      fb_we        <= cap_v && cap_di && wok;
      frame_strobe <= cap_v && !cap_di && cap_cs[0] && cap_d == 8'h00;
      if (cap_v && cap_di && wok) begin
        fb_x    <= wx[7:0];
        fb_y    <= {lower, wpage};
        fb_data <= cap_d;
      end
      for (int i = 0; i < LCD_MODULES; i++)
        if (cap_v && cap_cs[i]) begin
          if (cap_di) col[i] <= up[i] ? col[i] + 6'd1 : col[i] - 6'd1;
          else if (cap_d[7:1] == 7'h1C) display_on[i] <= cap_d[0];
          else if (cap_d[7:1] == 7'h1D) up[i] <= cap_d[0];
          else if (cap_d[5:0] == 6'h3E) start_page_unused[i] <= cap_d[7:6];
          else {page[i], col[i]} <= cap_d;
        end
    end
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: randomized scoreboard bench for lcd_capture against a chip-level reference model.
module tb_lcd_capture;
  logic clk = 0, reset = 0;
  logic [7:0] data_pin = 0;
  logic [9:0] cs_pin = 0;
  logic di_pin = 0, rw_pin = 0, enable_pin = 1, reset_pin = 1;
  logic fb_we, frame_strobe;
  logic [7:0] fb_x, fb_data;
  logic [2:0] fb_y;
  logic [9:0] display_on;

  lcd_capture dut (
    .clk(clk), .reset(reset), .data_pin(data_pin), .cs_pin(cs_pin), .di_pin(di_pin),
    .rw_pin(rw_pin), .enable_pin(enable_pin), .reset_pin(reset_pin), .fb_we(fb_we),
    .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data), .frame_strobe(frame_strobe),
    .display_on(display_on)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int x; int y; int d; int c;} wr_t;
  wr_t wq[$];
  int fq[$];
  int compared = 0, mismatched = 0;
  int col[10], pg[10];
  bit up[10];
  logic [9:0] disp;
  wr_t e;
  int fc;

  task automatic chk(string n, int a, int x);
    compared++;
    if (a != x) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, x, cyc);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 10; i++) begin
      col[i] = 0;
      pg[i] = 0;
      up[i] = 1;
    end
    disp = 0;
  endtask

  task automatic model(logic [9:0] cs, bit di, bit rw, int d);
    int m, x;
    if (rw || cs == 0 || !reset_pin) return;
    if (di) begin
      m = 0;
      while (!cs[m]) m++;
      x = col[m] + 50 * (m % 5);
      if (col[m] < 50 && x < 240) wq.push_back('{x, (m >= 5 ? 4 : 0) + pg[m], d, cyc + 4});
      for (int i = 0; i < 10; i++)
        if (cs[i]) col[i] = up[i] ? (col[i] + 1) % 64 : (col[i] + 63) % 64;
    end else begin
      if (cs[0] && d == 0) fq.push_back(cyc + 4);
      for (int i = 0; i < 10; i++)
        if (cs[i]) begin
          if (d == 8'h38 || d == 8'h39) disp[i] = d[0];
          else if (d == 8'h3A || d == 8'h3B) up[i] = d[0];
          else if (d % 64 != 62) begin
            pg[i] = d / 64;
            col[i] = d % 64;
          end
        end
    end
  endtask

  task automatic xfer(logic [9:0] cs, bit di, bit rw, int d);
    @(negedge clk);
    data_pin = 8'(d); cs_pin = cs; di_pin = di; rw_pin = rw;
    repeat (3) @(negedge clk);
    enable_pin = 0;
    model(cs, di, rw, d);
    repeat (4) @(negedge clk);
    enable_pin = 1;
    repeat (3) @(negedge clk);
    chk("display_on", display_on, disp);
  endtask

  always @(negedge clk) begin
    if (fb_we) begin
      if (wq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL fb_we: unexpected write x=%0d y=%0d data=%0d required none", fb_x, fb_y, fb_data);
      end else begin
        e = wq.pop_front();
        chk("fb_x", fb_x, e.x);
        chk("fb_y", fb_y, e.y);
        chk("fb_data", fb_data, e.d);
        chk("fb_we_cycle", cyc, e.c);
      end
    end
    if (frame_strobe) begin
      if (fq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL frame_strobe: unexpected pulse at cycle %0d required none", cyc);
      end else begin
        fc = fq.pop_front();
        chk("frame_cycle", cyc, fc);
      end
    end
  end

  initial begin
    logic [9:0] cs;
    bit di;
    int d;
    mreset();
    repeat (3) @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_x", fb_x, 0);
    chk("rst_fb_y", fb_y, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_frame", frame_strobe, 0);
    chk("rst_display", display_on, 0);
    reset = 1;
    repeat (4) @(negedge clk);
    xfer(10'h3FF, 0, 0, 8'h39);
    chk("all_on", display_on, 10'h3FF);
    xfer(10'h001, 0, 0, 8'h40);
    xfer(10'h001, 1, 0, 8'hA5);
    xfer(10'h001, 1, 0, 8'h3C);
    xfer(10'h080, 0, 0, 8'hC0 | 10);
    xfer(10'h080, 1, 0, 8'h5A);
    xfer(10'h001, 0, 0, 8'h3A);
    xfer(10'h001, 0, 0, 8'h00);
    xfer(10'h001, 1, 0, 8'h11);
    xfer(10'h001, 1, 0, 8'h22);
    xfer(10'h010, 0, 0, 8'h31);
    xfer(10'h010, 1, 0, 8'h77);
    xfer(10'h010, 0, 0, 8'h27);
    xfer(10'h010, 1, 0, 8'h88);
    xfer(10'h000, 1, 0, 8'h99);
    xfer(10'h001, 1, 1, 8'h55);
    reset_pin = 0;
    repeat (4) @(negedge clk);
    mreset();
    chk("rp_display", display_on, 0);
    xfer(10'h001, 0, 0, 8'h39);
    reset_pin = 1;
    repeat (4) @(negedge clk);
    xfer(10'h002, 0, 0, 8'h3E);
    xfer(10'h002, 1, 0, 8'h12);
    @(negedge clk);
    data_pin = 8'hEE; cs_pin = 10'h001; di_pin = 1; rw_pin = 0;
    repeat (3) @(negedge clk);
    enable_pin = 0;
    @(negedge clk);
    reset = 0;
    mreset();
    repeat (2) @(negedge clk);
    chk("arst_fb_we", fb_we, 0);
    chk("arst_fb_x", fb_x, 0);
    enable_pin = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    xfer(10'h001, 1, 0, 8'h44);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: cs = 10'(1) << $urandom_range(0, 9);
        3, 4:    cs = 10'($urandom);
        default: cs = 0;
      endcase
      di = $urandom_range(0, 1) == 1;
      d = $urandom_range(0, 255);
      if (!di && $urandom_range(0, 2) == 0) d = 8'h38 + $urandom_range(0, 3);
      xfer(cs, di, $urandom_range(0, 7) == 0, d);
    end
    repeat (10) @(negedge clk);
    chk("writes_pending", wq.size(), 0);
    chk("frames_pending", fq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
